// File: rtl/vote_collector_if.sv
// vote_collector_if: ballot collection and presentation signals between voters, collector and decoder
interface vote_collector_if;
    logic       open_i;
    logic [3:0] vote_valid_i;
    logic [3:0] vote_val_i;
    logic [3:0] ballot_o;
    logic       ballot_valid_o;
    logic       ballot_ready_i;
    logic [3:0] voted_o;
    logic       busy_o;
    logic       timeout_o;

    modport slave (
        input  open_i, vote_valid_i, vote_val_i, ballot_ready_i,
        output ballot_o, ballot_valid_o, voted_o, busy_o, timeout_o
    );

    modport master (
        output open_i, vote_valid_i, vote_val_i, ballot_ready_i,
        input  ballot_o, ballot_valid_o, voted_o, busy_o, timeout_o
    );
endinterface

// File: rtl/vote_collector.sv
// vote_collector: collects four yes/no ballots per round and presents them with valid/ready
module vote_collector #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TW             = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    vote_collector_if.slave   bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    r_state;
    logic [3:0]    r_ballot;
    logic [3:0]    r_voted;
    logic [TW-1:0] r_timer;
    logic          r_timeout;
    logic [3:0]    w_accept;
    logic [3:0]    w_voted_nx;
    logic [3:0]    w_ballot_nx;

    // first strobe per voter wins; later strobes from a voted voter are dropped
    always_comb begin
        w_accept    = bus.vote_valid_i & ~r_voted;
        w_voted_nx  = r_voted | w_accept;
        w_ballot_nx = (r_ballot & ~w_accept) | (bus.vote_val_i & w_accept);
    end

    // round FSM: open in IDLE, gather votes until all voted or timer expires, hold until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ballot  <= '0;
            r_voted   <= '0;
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.open_i) begin
                        r_state   <= COLLECT;
                        r_ballot  <= '0;
                        r_voted   <= '0;
                        r_timer   <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                COLLECT: begin
                    r_ballot <= w_ballot_nx;
                    r_voted  <= w_voted_nx;
                    r_timer  <= r_timer + TW'(1);
                    if (&w_voted_nx) begin
                        r_state   <= PRESENT;
                        r_timeout <= 1'b0;
                    end else if (r_timer == LAST) begin
                        r_state   <= PRESENT;
                        r_timeout <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (bus.ballot_ready_i) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ballot_o       = r_ballot;
    assign bus.voted_o        = r_voted;
    assign bus.timeout_o      = r_timeout;
    assign bus.ballot_valid_o = (r_state == PRESENT);
    assign bus.busy_o         = (r_state != IDLE);
endmodule

// File: tb/tb_vote_collector.sv
// tb_vote_collector: directed table-driven check of the vote collector with an 8-cycle timeout
module tb_vote_collector;
    localparam int T = 8;

    typedef struct {
        logic       open;
        logic [3:0] vv;
        logic [3:0] val;
        logic       rdy;
        logic [3:0] e_ballot;
        logic       e_valid;
        logic [3:0] e_voted;
        logic       e_busy;
        logic       e_to;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];

    vote_collector_if bus();

    vote_collector #(.TIMEOUT_CYCLES(T), .TW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] b, input logic v,
                           input logic [3:0] vd, input logic bz, input logic to);
        chk({tag, " ballot"}, bus.ballot_o, b);
        chk({tag, " valid"}, {3'b0, bus.ballot_valid_o}, {3'b0, v});
        chk({tag, " voted"}, bus.voted_o, vd);
        chk({tag, " busy"}, {3'b0, bus.busy_o}, {3'b0, bz});
        chk({tag, " timeout"}, {3'b0, bus.timeout_o}, {3'b0, to});
    endtask

    task automatic add(input logic o, input logic [3:0] vv, input logic [3:0] val, input logic r,
                       input logic [3:0] eb, input logic ev, input logic [3:0] evd,
                       input logic ebz, input logic eto);
        vec_t v;
        v = '{o, vv, val, r, eb, ev, evd, ebz, eto};
        vq.push_back(v);
    endtask

    task automatic drive(input logic o, input logic [3:0] vv, input logic [3:0] val, input logic r);
        bus.open_i = o;
        bus.vote_valid_i = vv;
        bus.vote_val_i = val;
        bus.ballot_ready_i = r;
    endtask

    initial begin
        drive(0, 0, 0, 0);
        #1 chk_all("reset", 4'b0, 0, 4'b0, 0, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // plan 1: sequential votes, closes on the fourth
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 1, 0);
        add(0, 4'b0001, 4'b0001, 0, 4'b0001, 0, 4'b0001, 1, 0);
        add(0, 4'b0010, 4'b0010, 0, 4'b0011, 0, 4'b0011, 1, 0);
        add(0, 4'b0100, 4'b0000, 0, 4'b0011, 0, 4'b0111, 1, 0);
        add(0, 4'b1000, 4'b1000, 0, 4'b1011, 1, 4'b1111, 1, 0);
        add(0, 4'b0000, 4'b0000, 1, 4'b1011, 0, 4'b1111, 0, 0);
        // plan 3a: voter 1 re-strobes with a different value
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 1, 0);
        add(0, 4'b0010, 4'b0010, 0, 4'b0010, 0, 4'b0010, 1, 0);
        add(0, 4'b0010, 4'b0000, 0, 4'b0010, 0, 4'b0010, 1, 0);
        add(0, 4'b1111, 4'b1101, 0, 4'b1111, 1, 4'b1111, 1, 0);
        add(0, 4'b0000, 4'b0000, 1, 4'b1111, 0, 4'b1111, 0, 0);
        // plan 3b: all four on the first collect cycle
        add(1, 4'b1111, 4'b1111, 0, 4'b0000, 0, 4'b0000, 1, 0);
        add(0, 4'b1111, 4'b0110, 0, 4'b0110, 1, 4'b1111, 1, 0);
        add(0, 4'b0000, 4'b0000, 1, 4'b0110, 0, 4'b1111, 0, 0);
        // plan 2: timeout with voters 0 and 2 only, valid exactly T cycles after entry
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 1, 0);
        add(0, 4'b0001, 4'b0001, 0, 4'b0001, 0, 4'b0001, 1, 0);
        add(0, 4'b0100, 4'b0100, 0, 4'b0101, 0, 4'b0101, 1, 0);
        for (int i = 0; i < T - 3; i++) add(0, 4'b0000, 4'b0000, 0, 4'b0101, 0, 4'b0101, 1, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0101, 1, 4'b0101, 1, 1);
        add(0, 4'b0000, 4'b0000, 1, 4'b0101, 0, 4'b0101, 0, 1);
        // plan 4: last vote lands on the timeout edge
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 1, 0);
        add(0, 4'b0111, 4'b0011, 0, 4'b0011, 0, 4'b0111, 1, 0);
        for (int i = 0; i < T - 2; i++) add(1, 4'b0000, 4'b0000, 1, 4'b0011, 0, 4'b0111, 1, 0);
        add(0, 4'b1000, 4'b1000, 0, 4'b1011, 1, 4'b1111, 1, 0);
        // plan 5: stalled present ignores votes/open, open on handshake edge ignored
        for (int i = 0; i < 5; i++) add(1, 4'b1111, 4'b0000, 0, 4'b1011, 1, 4'b1111, 1, 0);
        add(1, 4'b1111, 4'b0000, 1, 4'b1011, 0, 4'b1111, 0, 0);
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 1, 0);
        add(1, 4'b0011, 4'b0011, 0, 4'b0011, 0, 4'b0011, 1, 0);

        foreach (vq[i]) begin
            drive(vq[i].open, vq[i].vv, vq[i].val, vq[i].rdy);
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), vq[i].e_ballot, vq[i].e_valid,
                    vq[i].e_voted, vq[i].e_busy, vq[i].e_to);
        end

        // plan 6: asynchronous reset mid-collect with voted = 0011
        drive(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 4'b0, 0, 4'b0, 0, 0);
        #2 rst_n = 1'b1;
        drive(0, 4'b1111, 4'b1111, 0);
        @(posedge clk); #1 chk_all("post_rst_vote", 4'b0, 0, 4'b0, 0, 0);
        drive(1, 4'b0000, 4'b0000, 0);
        @(posedge clk); #1 chk_all("post_rst_open", 4'b0, 0, 4'b0, 1, 0);
        drive(0, 4'b1111, 4'b1001, 0);
        @(posedge clk); #1 chk_all("post_rst_vote2", 4'b1001, 1, 4'b1111, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
